ctrl_decode_stage: RTL and testbench

Registered, parametrised control/decode stage for the RV32I/RV64I core pipeline, sitting between the register-file read and the execute stage. It generates datapath control signals and resolves branches with correct signed/unsigned comparison. Results are held in a valid/ready output register. A load-use interlock holds dependent instructions for a configurable number of cycles, and a flush input kills in-flight state.

---
 rtl/ctrl_decode_stage.sv | 229 ++++++++++++++++++++++
 tb/tb_ctrl_decode_stage.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_decode_stage.sv
// Control/decode stage: decodes the opcode, resolves branches and registers the result
// behind a valid/ready output register, with a load-use interlock and a flush.
module ctrl_decode_stage #(
    parameter int XLEN           = 32,
    parameter int LOAD_USE_STALL = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [6:0]      opcode,
    input  logic [2:0]      funct3,
    input  logic [4:0]      rd,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    input  logic [XLEN-1:0] rf1,
    input  logic [XLEN-1:0] rf2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            mem_read,
    output logic            mem_write,
    output logic            mem_to_reg,
    output logic            reg_wr_en,
    output logic            alu_src,
    output logic            is_branch,
    output logic            is_jump,
    output logic            is_return,
    output logic            branch_taken,
    output logic            jump_taken,
    output logic            signed_imm,
    output logic            illegal,
    output logic [4:0]      out_rd
);

    localparam logic [6:0] OPC_OP      = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_LOAD_FP = 7'b0000111;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;
    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
    localparam logic [2:0] STALL_INIT  = 3'(LOAD_USE_STALL);

    typedef struct packed {
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
        logic reg_wr_en;
        logic alu_src;
        logic is_branch;
        logic is_jump;
        logic is_return;
        logic branch_taken;
        logic jump_taken;
        logic signed_imm;
        logic illegal;
    } ctrl_t;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    ctrl_t      ctrl_next;
    ctrl_t      ctrl_reg;
    logic       out_valid_reg;
    logic [4:0] out_rd_reg;
    state_t     state_reg;
    state_t     state_next;
    logic [2:0] cnt_reg;
    logic [2:0] cnt_next;
    logic [4:0] held_rd_reg;
    logic [4:0] held_rd_next;

    logic eq;
    logic lt_s;
    logic lt_u;
    assign eq   = (rf1 == rf2);
    assign lt_s = ($signed(rf1) < $signed(rf2));
    assign lt_u = (rf1 < rf2);

    always_comb begin
        ctrl_next = '0;
        case (opcode)
            OPC_OP: ctrl_next.reg_wr_en = 1'b1;
            OPC_OP_IMM: begin
                ctrl_next.reg_wr_en  = 1'b1;
                ctrl_next.alu_src    = 1'b1;
                ctrl_next.signed_imm = 1'b1;
            end
            OPC_LOAD, OPC_LOAD_FP: begin
                ctrl_next.reg_wr_en  = 1'b1;
                ctrl_next.alu_src    = 1'b1;
                ctrl_next.mem_read   = 1'b1;
                ctrl_next.mem_to_reg = 1'b1;
                ctrl_next.signed_imm = 1'b1;
            end
            OPC_STORE: begin
                ctrl_next.alu_src    = 1'b1;
                ctrl_next.mem_write  = 1'b1;
                ctrl_next.signed_imm = 1'b1;
            end
            OPC_BRANCH: begin
                ctrl_next.is_branch  = 1'b1;
                ctrl_next.signed_imm = 1'b1;
                case (funct3)
                    3'b000:  ctrl_next.branch_taken = eq;
                    3'b001:  ctrl_next.branch_taken = !eq;
                    3'b100:  ctrl_next.branch_taken = lt_s;
                    3'b101:  ctrl_next.branch_taken = !lt_s;
                    3'b110:  ctrl_next.branch_taken = lt_u;
                    3'b111:  ctrl_next.branch_taken = !lt_u;
                    default: ctrl_next.illegal      = 1'b1;
                endcase
            end
            OPC_JAL: begin
                ctrl_next.reg_wr_en  = 1'b1;
                ctrl_next.is_jump    = 1'b1;
                ctrl_next.jump_taken = 1'b1;
            end
            OPC_JALR: begin
                ctrl_next.reg_wr_en  = 1'b1;
                ctrl_next.alu_src    = 1'b1;
                ctrl_next.is_jump    = 1'b1;
                ctrl_next.jump_taken = 1'b1;
                ctrl_next.signed_imm = 1'b1;
                ctrl_next.is_return  = (rd == 5'd0) && (rs1 == 5'd1);
            end
            OPC_LUI, OPC_AUIPC: ctrl_next.reg_wr_en = 1'b1;
            default: ctrl_next.illegal = 1'b1;
        endcase
    end

    // Two hazard producers: a load sitting in the output register, and the load held by the interlock.
    logic            use_rs1;
    logic            use_rs2;
    logic [1:0]      prod_active;
    logic [1:0][4:0] prod_rd;
    logic [1:0]      hit;
    logic            hazard;
    logic            accept;
    logic            load_xfer;

    assign use_rs1 = !((opcode == OPC_JAL) || (opcode == OPC_LUI) || (opcode == OPC_AUIPC));
    assign use_rs2 = (opcode == OPC_OP) || (opcode == OPC_STORE) || (opcode == OPC_BRANCH);

    assign prod_active[0] = out_valid_reg && ctrl_reg.mem_read;
    assign prod_rd[0]     = out_rd_reg;
    assign prod_active[1] = (state_reg == STALL);
    assign prod_rd[1]     = held_rd_reg;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_hazard
            assign hit[gi] = prod_active[gi] && (prod_rd[gi] != 5'd0) &&
                             ((use_rs1 && (rs1 == prod_rd[gi])) ||
                              (use_rs2 && (rs2 == prod_rd[gi])));
        end
    endgenerate

    assign hazard    = |hit;
    assign in_ready  = (!out_valid_reg || out_ready) && !hazard;
    assign accept    = in_valid && in_ready;
    assign load_xfer = out_valid_reg && out_ready && ctrl_reg.mem_read && (out_rd_reg != 5'd0);

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            out_valid_reg <= 1'b0;
            ctrl_reg      <= '0;
            out_rd_reg    <= 5'd0;
        end else if (accept) begin
            out_valid_reg <= 1'b1;
            ctrl_reg      <= ctrl_next;
            out_rd_reg    <= rd;
        end else if (out_ready) begin
            out_valid_reg <= 1'b0;
            ctrl_reg      <= '0;
            out_rd_reg    <= 5'd0;
        end
    end

    // A departing load always reloads the hold register, even mid-stall.
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        held_rd_next = held_rd_reg;
        if (load_xfer) begin
            held_rd_next = out_rd_reg;
            cnt_next     = STALL_INIT;
            state_next   = (LOAD_USE_STALL > 0) ? STALL : RUN;
        end else if (state_reg == STALL) begin
            cnt_next = cnt_reg - 3'd1;
            if (cnt_reg == 3'd1) begin
                state_next = RUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            state_reg   <= RUN;
            cnt_reg     <= 3'd0;
            held_rd_reg <= 5'd0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            held_rd_reg <= held_rd_next;
        end
    end

    assign out_valid    = out_valid_reg;
    assign out_rd       = out_rd_reg;
    assign mem_read     = ctrl_reg.mem_read;
    assign mem_write    = ctrl_reg.mem_write;
    assign mem_to_reg   = ctrl_reg.mem_to_reg;
    assign reg_wr_en    = ctrl_reg.reg_wr_en;
    assign alu_src      = ctrl_reg.alu_src;
    assign is_branch    = ctrl_reg.is_branch;
    assign is_jump      = ctrl_reg.is_jump;
    assign is_return    = ctrl_reg.is_return;
    assign branch_taken = ctrl_reg.branch_taken;
    assign jump_taken   = ctrl_reg.jump_taken;
    assign signed_imm   = ctrl_reg.signed_imm;
    assign illegal      = ctrl_reg.illegal;

endmodule

// File: tb/tb_ctrl_decode_stage.sv
// Scoreboard bench for ctrl_decode_stage: expected decode results are queued on acceptance
// and compared when the stage hands the instruction downstream.
module tb_ctrl_decode_stage;

    localparam logic [6:0] OP      = 7'b0110011;
    localparam logic [6:0] OP_IMM  = 7'b0010011;
    localparam logic [6:0] LOAD    = 7'b0000011;
    localparam logic [6:0] LOAD_FP = 7'b0000111;
    localparam logic [6:0] STORE   = 7'b0100011;
    localparam logic [6:0] BRANCH  = 7'b1100011;
    localparam logic [6:0] JAL     = 7'b1101111;
    localparam logic [6:0] JALR    = 7'b1100111;
    localparam logic [6:0] LUI     = 7'b0110111;
    localparam logic [6:0] AUIPC   = 7'b0010111;
    localparam logic [6:0] FENCE   = 7'b0001111;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] rf1, rf2;
    logic        out_valid;
    logic        out_ready;
    logic        mem_read, mem_write, mem_to_reg, reg_wr_en, alu_src, is_branch;
    logic        is_jump, is_return, branch_taken, jump_taken, signed_imm, illegal;
    logic [4:0]  out_rd;
    logic [16:0] obs;

    int n_tests = 0;
    int n_fail  = 0;
    int n_txn   = 0;
    logic [16:0] exp_q[$];
    logic [16:0] exp_v;

    ctrl_decode_stage #(.XLEN(32), .LOAD_USE_STALL(1)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .funct3(funct3), .rd(rd), .rs1(rs1), .rs2(rs2),
        .rf1(rf1), .rf2(rf2),
        .out_valid(out_valid), .out_ready(out_ready),
        .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
        .reg_wr_en(reg_wr_en), .alu_src(alu_src), .is_branch(is_branch),
        .is_jump(is_jump), .is_return(is_return), .branch_taken(branch_taken),
        .jump_taken(jump_taken), .signed_imm(signed_imm), .illegal(illegal),
        .out_rd(out_rd)
    );

    assign obs = {mem_read, mem_write, mem_to_reg, reg_wr_en, alu_src, is_branch,
                  is_jump, is_return, branch_taken, jump_taken, signed_imm, illegal, out_rd};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Bit order: mem_read mem_write mem_to_reg reg_wr_en alu_src is_branch is_jump
    // is_return branch_taken jump_taken signed_imm illegal, then rd.
    function automatic logic [16:0] model(input logic [6:0] op, input logic [2:0] f3,
                                          input logic [4:0] d, input logic [4:0] s1,
                                          input logic [31:0] a, input logic [31:0] b);
        logic [11:0] c;
        logic [31:0] as_, bs_;
        as_ = a ^ 32'h8000_0000;
        bs_ = b ^ 32'h8000_0000;
        c   = 12'b0000_0000_0001;
        case (op)
            OP:            c = 12'b0001_0000_0000;
            OP_IMM:        c = 12'b0001_1000_0010;
            LOAD, LOAD_FP: c = 12'b1011_1000_0010;
            STORE:         c = 12'b0100_1000_0010;
            BRANCH: begin
                c = 12'b0000_0100_0010;
                case (f3)
                    3'd0:    c[3] = (a == b);
                    3'd1:    c[3] = (a != b);
                    3'd4:    c[3] = (as_ < bs_);
                    3'd5:    c[3] = !(as_ < bs_);
                    3'd6:    c[3] = (a < b);
                    3'd7:    c[3] = !(a < b);
                    default: c[0] = 1'b1;
                endcase
            end
            JAL:  c = 12'b0001_0010_0100;
            JALR: begin
                c = 12'b0001_1010_0110;
                if (d == 5'd0 && s1 == 5'd1) c[4] = 1'b1;
            end
            LUI, AUIPC: c = 12'b0001_0000_0000;
            default:    c = 12'b0000_0000_0001;
        endcase
        return {c, d};
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            if (!out_valid) check_val("idle_zero", obs, 17'd0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check_val("unexpected_out", out_valid, 1'b0);
                end else begin
                    exp_v = exp_q.pop_front();
                    n_txn++;
                    $display("[TB] txn %0d rd=%0d ctrl=%03h expected=%03h",
                             n_txn, out_rd, obs[16:5], exp_v[16:5]);
                    check_val("txn", obs, exp_v);
                end
            end
            if (flush) exp_q.delete();
            else if (in_valid && in_ready) exp_q.push_back(model(opcode, funct3, rd, rs1, rf1, rf2));
        end
    end

    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] d,
                         input logic [4:0] s1, input logic [4:0] s2,
                         input logic [31:0] a, input logic [31:0] b);
        opcode = op; funct3 = f3; rd = d; rs1 = s1; rs2 = s2; rf1 = a; rf2 = b;
        in_valid = 1'b1;
    endtask

    // Presents an instruction until accepted; returns the number of refused cycles.
    task automatic send(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] d,
                        input logic [4:0] s1, input logic [4:0] s2,
                        input logic [31:0] a, input logic [31:0] b, output int stalls);
        int k;
        drive(op, f3, d, s1, s2, a, b);
        for (k = 0; k < 50; k++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        stalls = k;
        if (k == 50) check_val("accept_timeout", in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int st;
        logic [31:0] a, b;
        logic [2:0] f3s [6];
        f3s = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};

        // Reset with a valid instruction presented
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
        drive(OP, 3'd0, 5'd3, 5'd1, 5'd2, 32'd0, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check_val("reset_out_valid", out_valid, 1'b0);
        check_val("reset_ctrl", obs, 17'd0);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(negedge clk);
        check_val("reset_in_ready", in_ready, 1'b1);
        @(posedge clk); #1;

        // Branch compare signedness, one-cycle latency
        send(BRANCH, 3'b110, 5'd0, 5'd1, 5'd2, 32'h0000_0001, 32'hFFFF_FFFF, st);
        check_val("bltu_latency", out_valid, 1'b1);
        check_val("bltu_taken", branch_taken, 1'b1);
        send(BRANCH, 3'b100, 5'd0, 5'd1, 5'd2, 32'h0000_0001, 32'hFFFF_FFFF, st);
        check_val("blt_taken", branch_taken, 1'b0);
        send(BRANCH, 3'b101, 5'd0, 5'd1, 5'd2, 32'd5, 32'd5, st);
        check_val("bge_taken", branch_taken, 1'b1);

        // Load-use interlock: LW x5 then ADD x6,x5,x7
        send(LOAD, 3'b010, 5'd5, 5'd1, 5'd0, 32'd0, 32'd0, st);
        send(OP, 3'd0, 5'd6, 5'd5, 5'd7, 32'd0, 32'd0, st);
        check_val("load_use_stalls", st, 2);
        send(LOAD, 3'b010, 5'd0, 5'd2, 5'd0, 32'd0, 32'd0, st);
        send(OP, 3'd0, 5'd6, 5'd0, 5'd7, 32'd0, 32'd0, st);
        check_val("load_x0_stalls", st, 0);

        // Backpressure: hold output for 3 cycles
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b0;
        send(OP, 3'd0, 5'd8, 5'd1, 5'd2, 32'd0, 32'd0, st);
        drive(OP_IMM, 3'd0, 5'd12, 5'd3, 5'd0, 32'd0, 32'd0);
        repeat (3) begin
            @(negedge clk);
            check_val("bp_in_ready", in_ready, 1'b0);
            check_val("bp_out_valid", out_valid, 1'b1);
            check_val("bp_out_rd", out_rd, 5'd8);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(OP_IMM, 3'd0, 5'd12, 5'd3, 5'd0, 32'd0, 32'd0, st);

        // Flush on the bubble cycle
        send(LOAD, 3'b010, 5'd9, 5'd1, 5'd0, 32'd0, 32'd0, st);
        drive(OP, 3'd0, 5'd10, 5'd9, 5'd0, 32'd0, 32'd0);
        @(negedge clk);
        check_val("flush_pre_ready", in_ready, 1'b0);
        @(posedge clk); #1;
        flush = 1'b1;
        @(negedge clk);
        check_val("flush_in_ready", in_ready, 1'b0);
        @(posedge clk); #1;
        flush = 1'b0;
        check_val("flush_out_valid", out_valid, 1'b0);
        @(negedge clk);
        check_val("flush_dep_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_val("flush_dep_out", {out_valid, out_rd}, {1'b1, 5'd10});

        // Flush overriding a load transfer must not start a stall
        send(LOAD, 3'b010, 5'd13, 5'd1, 5'd0, 32'd0, 32'd0, st);
        drive(OP, 3'd0, 5'd14, 5'd13, 5'd0, 32'd0, 32'd0);
        flush = 1'b1;
        @(negedge clk);
        check_val("flushx_in_ready", in_ready, 1'b0);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        check_val("flushx_no_stall", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;

        // Decode sweep
        send(OP,      3'd0, 5'd1,  5'd2, 5'd3, 32'd0, 32'd0, st);
        send(OP_IMM,  3'd0, 5'd2,  5'd3, 5'd0, 32'd0, 32'd0, st);
        send(LOAD,    3'd2, 5'd11, 5'd3, 5'd0, 32'd0, 32'd0, st);
        send(LOAD_FP, 3'd2, 5'd4,  5'd3, 5'd0, 32'd0, 32'd0, st);
        send(STORE,   3'd2, 5'd0,  5'd1, 5'd2, 32'd0, 32'd0, st);
        send(BRANCH,  3'd0, 5'd0,  5'd1, 5'd2, 32'd7, 32'd7, st);
        send(JAL,     3'd0, 5'd1,  5'd0, 5'd0, 32'd0, 32'd0, st);
        send(JALR,    3'd0, 5'd0,  5'd1, 5'd0, 32'd0, 32'd0, st);
        check_val("jalr_is_return", is_return, 1'b1);
        send(JALR,    3'd0, 5'd3,  5'd1, 5'd0, 32'd0, 32'd0, st);
        send(LUI,     3'd0, 5'd7,  5'd0, 5'd0, 32'd0, 32'd0, st);
        send(AUIPC,   3'd0, 5'd8,  5'd0, 5'd0, 32'd0, 32'd0, st);
        send(FENCE,   3'd0, 5'd9,  5'd1, 5'd0, 32'd0, 32'd0, st);
        check_val("fence_illegal", {illegal, reg_wr_en}, 2'b10);
        send(BRANCH,  3'd2, 5'd0,  5'd1, 5'd2, 32'd1, 32'd2, st);

        // Random branch operands across all comparison kinds
        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            b = $urandom;
            if (i % 4 == 0) b = a;
            if (i % 3 == 0) b = a ^ 32'h8000_0000;
            send(BRANCH, f3s[i % 6], 5'd0, 5'd3, 5'd4, a, b, st);
        end

        repeat (3) @(posedge clk);
        #1;
        check_val("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
